// File: rtl/ps2_op_queue.sv
// ps2_op_queue: PS/2 scan-code parser with held-key tracking and a show-ahead op FIFO
module ps2_op_queue #(
  parameter int OP_W           = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int REPEAT_EN      = 0,
  parameter int PREFIX_TIMEOUT = 2000000
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    scan_code,
  input  logic                          scan_valid,
  input  logic                          op_ready,
  input  logic                          ovf_clr,
  output logic [OP_W-1:0]               op,
  output logic                          op_valid,
  output logic [7:0]                    held,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = PREFIX_TIMEOUT > 1 ? $clog2(PREFIX_TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  state_t          r_state;
  logic [TW-1:0]   r_tcnt;
  logic [7:0]      r_held;
  logic [OP_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wp, r_rp;
  logic [AW:0]     r_cnt;
  logic [OP_W-1:0] r_op;
  logic            r_valid, r_ovf;
  logic            w_e0, w_f0, w_ext, w_make, w_brk, w_push, w_pop, w_full, w_wr;
  logic            w_ovf_set, w_tmo_on, w_tout;
  logic [3:0]      w_nk, w_ek, w_k;
  logic [7:0]      w_hbit;
  logic [OP_W-1:0] w_opk, w_head;
  logic [AW-1:0]   w_nrp;
  logic [AW:0]     w_ncnt;
  always_comb begin
    w_nk = 4'd0;
    w_ek = 4'd0;
    case (scan_code)
      8'h1D: w_nk = 4'd1;
      8'h1B: w_nk = 4'd2;
      8'h1C: w_nk = 4'd3;
      8'h23: w_nk = 4'd4;
      8'h5A: w_nk = 4'd5;
      8'h55: w_nk = 4'd6;
      8'h4E: w_nk = 4'd7;
      8'h29: w_nk = 4'd8;
      default: ;
    endcase
    case (scan_code)
      8'h75: w_ek = 4'd1;
      8'h72: w_ek = 4'd2;
      8'h6B: w_ek = 4'd3;
      8'h74: w_ek = 4'd4;
      8'h5A: w_ek = 4'd5;
      default: ;
    endcase
  end
  assign w_e0      = scan_code == 8'hE0;
  assign w_f0      = scan_code == 8'hF0;
  assign w_ext     = r_state == EXT || r_state == EXT_BRK;
  assign w_make    = scan_valid && (r_state == IDLE || r_state == EXT) && !w_e0 && !w_f0;
  assign w_brk     = scan_valid && (r_state == BRK || r_state == EXT_BRK);
  assign w_k       = w_ext ? w_ek : w_nk;
  // one-hot held bit for op k; zero for unmapped codes
  assign w_hbit    = 8'((9'd1 << w_k) >> 1);
  assign w_opk     = OP_W'(w_k);
  assign w_push    = w_make && (w_hbit != 8'd0) && (REPEAT_EN != 0 || (r_held & w_hbit) == 8'd0);
  assign w_pop     = r_valid && op_ready;
  assign w_full    = r_cnt == (AW+1)'(FIFO_DEPTH);
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;
  assign w_ncnt    = r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_pop);
  assign w_nrp     = w_pop ? r_rp + AW'(1) : r_rp;
  // the next head may be the entry being written this very cycle
  assign w_head    = (w_wr && w_nrp == r_wp) ? w_opk : r_mem[w_nrp];
  assign w_tmo_on  = PREFIX_TIMEOUT != 0 && r_state != IDLE;
  assign w_tout    = r_tcnt == TW'(PREFIX_TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_tcnt  <= '0;
    end else if (scan_valid) begin
      r_tcnt  <= '0;
      r_state <= r_state == IDLE ? (w_e0 ? EXT : w_f0 ? BRK : IDLE)
               : r_state == EXT  ? (w_f0 ? EXT_BRK : w_e0 ? EXT : IDLE) : IDLE;
    end else if (w_tmo_on) begin
      r_tcnt <= w_tout ? '0 : r_tcnt + TW'(1);
      if (w_tout) r_state <= IDLE;
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= w_opk;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_op    <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_held  <= '0;
    end else begin
      r_wp    <= w_wr ? r_wp + AW'(1) : r_wp;
      r_rp    <= w_nrp;
      r_cnt   <= w_ncnt;
      r_valid <= w_ncnt != '0;
      r_op    <= w_ncnt != '0 ? w_head : '0;
      r_ovf   <= w_ovf_set || (r_ovf && !ovf_clr);
      r_held  <= w_make ? (r_held | w_hbit) : w_brk ? (r_held & ~w_hbit) : r_held;
    end
  assign op         = r_op;
  assign op_valid   = r_valid;
  assign held       = r_held;
  assign fifo_count = r_cnt;
  assign overflow   = r_ovf;
endmodule
